// File: rtl/program_sequencer_nway_pkg.sv
// Shared types and width helpers for the N-way program sequencer.
// No logic; latency and backpressure are not applicable.
package program_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FILL   = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    function automatic int tag_width(input int pc_w, input int set_w, input int offset_w);
        return pc_w - set_w - offset_w;
    endfunction

    function automatic int line_words(input int offset_w);
        return 1 << offset_w;
    endfunction

    function automatic int num_ways(input int way_w);
        return 1 << way_w;
    endfunction

    // A direct-mapped cache still carries a 1-bit way index that is always zero.
    function automatic int idx_w(input int w);
        return (w > 0) ? w : 1;
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/program_sequencer_nway_if.sv
// Core control, ROM fill handshake and cache index bundle of the sequencer.
// Wiring only; ROM side is valid-qualified, the sequencer holds rom_address until rom_valid.
interface program_sequencer_nway_if
    import program_sequencer_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int JADDR_W  = 4,
    parameter int OFFSET_W = 3,
    parameter int SET_W    = 1,
    parameter int WAY_W    = 1,
    parameter int CNT_W    = 16
);
    logic                      flush;
    logic                      jmp;
    logic                      jmp_nz;
    logic                      dont_jmp;
    logic [JADDR_W-1:0]        jmp_addr;
    logic                      rom_req;
    logic [PC_W-1:0]           rom_address;
    logic                      rom_valid;
    logic                      hold_out;
    logic                      cache_wren;
    logic [SET_W-1:0]          cache_wrset;
    logic [idx_w(WAY_W)-1:0]   cache_wrway;
    logic [OFFSET_W-1:0]       cache_wroffset;
    logic [SET_W-1:0]          cache_rdset;
    logic [idx_w(WAY_W)-1:0]   cache_rdway;
    logic [OFFSET_W-1:0]       cache_rdoffset;
    logic [PC_W-1:0]           pc;
    logic [CNT_W-1:0]          hit_count;
    logic [CNT_W-1:0]          miss_count;

    modport master (
        input  flush, jmp, jmp_nz, dont_jmp, jmp_addr, rom_valid,
        output rom_req, rom_address, hold_out, cache_wren,
               cache_wrset, cache_wrway, cache_wroffset,
               cache_rdset, cache_rdway, cache_rdoffset,
               pc, hit_count, miss_count
    );

    modport slave (
        output flush, jmp, jmp_nz, dont_jmp, jmp_addr, rom_valid,
        input  rom_req, rom_address, hold_out, cache_wren,
               cache_wrset, cache_wrway, cache_wroffset,
               cache_rdset, cache_rdway, cache_rdoffset,
               pc, hit_count, miss_count
    );

endinterface

// File: rtl/program_sequencer_nway_cache_tag_store.sv
// Tag/valid arrays with parallel compare and per-set round-robin victim pointers.
// Lookup is combinational, updates land on the next edge; no backpressure.
module cache_tag_store
    import program_sequencer_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int SET_W = 1,
    parameter int WAY_W = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SET_W-1:0]        i_lk_set,
    input  logic [TAG_W-1:0]        i_lk_tag,
    output logic                    o_hit,
    output logic [idx_w(WAY_W)-1:0] o_hit_way,
    output logic [idx_w(WAY_W)-1:0] o_victim_way,
    input  logic                    i_alloc,
    input  logic                    i_validate,
    input  logic [SET_W-1:0]        i_val_set,
    input  logic [idx_w(WAY_W)-1:0] i_val_way,
    input  logic                    i_inval_all
);
    localparam int SETS   = 1 << SET_W;
    localparam int WAYS   = num_ways(WAY_W);
    localparam int WAY_IW = idx_w(WAY_W);

    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [WAY_IW-1:0] r_ptr   [SETS];
    logic [WAY_IW-1:0] w_ptr_inc;

    // Descending scan so the lowest hitting way wins.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[i_lk_set][w] && (r_tag[i_lk_set][w] == i_lk_tag)) begin
                o_hit     = 1'b1;
                o_hit_way = WAY_IW'(w);
            end
        end
    end

    assign o_victim_way = r_ptr[i_lk_set];
    assign w_ptr_inc    = (WAYS == 1) ? '0 : r_ptr[i_val_set] + WAY_IW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w] <= '0;
                end
            end
        end else if (i_inval_all) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else begin
            // The victim stays invalid until its last word arrives, so an aborted fill never hits.
            if (i_alloc) begin
                r_valid[i_lk_set][o_victim_way] <= 1'b0;
                r_tag[i_lk_set][o_victim_way]   <= i_lk_tag;
            end
            if (i_validate) begin
                r_valid[i_val_set][i_val_way] <= 1'b1;
                r_ptr[i_val_set]              <= w_ptr_inc;
            end
        end
    end

endmodule

// File: rtl/program_sequencer_nway.sv
// Program counter with jumps plus N-way I-cache tags; a miss stalls the core for a line fill.
// Hit: pc next cycle; miss: one ROM handshake per word + 2 cycles; waits on rom_valid indefinitely.
module program_sequencer_nway
    import program_sequencer_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int JADDR_W  = 4,
    parameter int OFFSET_W = 3,
    parameter int SET_W    = 1,
    parameter int WAY_W    = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    program_sequencer_nway_if.master bus
);
    localparam int TAG_W      = tag_width(PC_W, SET_W, OFFSET_W);
    localparam int LINE_WORDS = line_words(OFFSET_W);
    localparam int WAY_IW     = idx_w(WAY_W);

    state_t              r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pm_addr, w_target;
    logic                r_restart;
    logic [OFFSET_W-1:0] r_fill_cnt, w_fill_cnt_nxt;
    logic [WAY_IW-1:0]   r_fill_way, w_hit_way, w_victim_way;
    logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;
    logic                w_hit, w_alloc, w_validate, w_inval_all;
    logic                w_hit_inc, w_miss_inc, w_last_word;
    logic                w_rom_req, w_hold, w_wren;

    assign w_target = {bus.jmp_addr, {(PC_W - JADDR_W){1'b0}}};

    // r_restart re-presents pc once after reset or flush so address 0 itself is fetched.
    always_comb begin
        w_pm_addr = r_pc + PC_W'(1);
        if (bus.flush) begin
            w_pm_addr = '0;
        end else if ((r_state != ST_RUN) || r_restart) begin
            w_pm_addr = r_pc;
        end else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
            w_pm_addr = w_target;
        end
    end

    cache_tag_store #(
        .TAG_W (TAG_W),
        .SET_W (SET_W),
        .WAY_W (WAY_W)
    ) u_tags (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_lk_set     (w_pm_addr[OFFSET_W +: SET_W]),
        .i_lk_tag     (w_pm_addr[PC_W-1 -: TAG_W]),
        .o_hit        (w_hit),
        .o_hit_way    (w_hit_way),
        .o_victim_way (w_victim_way),
        .i_alloc      (w_alloc),
        .i_validate   (w_validate),
        .i_val_set    (r_pc[OFFSET_W +: SET_W]),
        .i_val_way    (r_fill_way),
        .i_inval_all  (w_inval_all)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_hold         = 1'b1;
        w_rom_req      = 1'b0;
        w_wren         = 1'b0;
        w_alloc        = 1'b0;
        w_validate     = 1'b0;
        w_inval_all    = 1'b0;
        w_hit_inc      = 1'b0;
        w_miss_inc     = 1'b0;
        w_last_word    = (r_fill_cnt == OFFSET_W'(LINE_WORDS - 1));
        if (bus.flush) begin
            w_inval_all    = 1'b1;
            w_state_nxt    = ST_RUN;
            w_fill_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hit) begin
                        w_hold    = 1'b0;
                        w_hit_inc = 1'b1;
                    end else begin
                        w_miss_inc     = 1'b1;
                        w_alloc        = 1'b1;
                        w_state_nxt    = ST_FILL;
                        w_fill_cnt_nxt = '0;
                    end
                end
                ST_FILL: begin
                    w_rom_req = 1'b1;
                    if (bus.rom_valid) begin
                        w_wren         = 1'b1;
                        w_fill_cnt_nxt = r_fill_cnt + OFFSET_W'(1);
                        if (w_last_word) begin
                            w_validate  = 1'b1;
                            w_state_nxt = ST_RESUME;
                        end
                    end
                end
                ST_RESUME: begin
                    w_hold      = 1'b0;
                    w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_pc       <= '0;
            r_restart  <= 1'b1;
            r_fill_cnt <= '0;
            r_fill_way <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pm_addr;
            r_restart  <= bus.flush;
            r_fill_cnt <= w_fill_cnt_nxt;
            if (w_alloc) begin
                r_fill_way <= w_victim_way;
            end
            if (w_hit_inc) begin
                r_hit_cnt <= CNT_W'(sat_inc(64'(r_hit_cnt), CNT_W));
            end
            if (w_miss_inc) begin
                r_miss_cnt <= CNT_W'(sat_inc(64'(r_miss_cnt), CNT_W));
            end
        end
    end

    assign bus.rom_req        = w_rom_req;
    assign bus.rom_address    = {r_pc[PC_W-1:OFFSET_W], r_fill_cnt};
    assign bus.hold_out       = w_hold;
    assign bus.cache_wren     = w_wren;
    assign bus.cache_wrset    = r_pc[OFFSET_W +: SET_W];
    assign bus.cache_wrway    = r_fill_way;
    assign bus.cache_wroffset = r_fill_cnt;
    assign bus.cache_rdset    = w_pm_addr[OFFSET_W +: SET_W];
    assign bus.cache_rdway    = w_hit_way;
    assign bus.cache_rdoffset = w_pm_addr[OFFSET_W-1:0];
    assign bus.pc             = r_pc;
    assign bus.hit_count      = r_hit_cnt;
    assign bus.miss_count     = r_miss_cnt;

endmodule

// File: tb/tb_program_sequencer_nway.sv
// Directed bench for program_sequencer_nway: fills, hits, eviction order, jumps, stalls, flush, reset.
// Default parameters: 8-bit pc, 8-word lines, 2 sets, 2 ways.
module tb_program_sequencer_nway;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    program_sequencer_nway_if bus ();

    program_sequencer_nway dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_pc;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.jmp       = 1'b0;
        bus.jmp_nz    = 1'b0;
        bus.dont_jmp  = 1'b0;
        bus.jmp_addr  = 4'h0;
        bus.rom_valid = 1'b0;
    endtask

    // Caller has already driven the inputs that make addr the missing fetch address.
    task automatic miss_fill(input logic [7:0] addr, input logic way, input int stall, input bit pulse);
        logic [7:0] base;
        logic [7:0] wa;
        logic       set;
        base   = {addr[7:3], 3'b000};
        set    = addr[3];
        exp_pc = addr;
        #1;
        n_vec++;
        if ({bus.hold_out, bus.rom_req, bus.cache_wren, bus.cache_rdset} !== {3'b100, set}) begin
            n_err++;
            $display("FAIL miss_cycle %h: got %b want %b", addr,
                     {bus.hold_out, bus.rom_req, bus.cache_wren, bus.cache_rdset}, {3'b100, set});
        end
        clk_edge();
        exp_miss++;
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            wa = base | 8'(k);
            for (int s = 0; s < stall; s++) begin
                bus.rom_valid = 1'b0;
                bus.jmp       = pulse && (s == 0);
                bus.jmp_addr  = 4'hF;
                #1;
                n_vec++;
                if ({bus.hold_out, bus.rom_req, bus.cache_wren, bus.rom_address} !== {3'b110, wa}) begin
                    n_err++;
                    $display("FAIL fill_wait %h: got %h want %h", wa,
                             {bus.hold_out, bus.rom_req, bus.cache_wren, bus.rom_address}, {3'b110, wa});
                end
                clk_edge();
            end
            bus.jmp       = 1'b0;
            bus.jmp_addr  = 4'h0;
            bus.rom_valid = 1'b1;
            #1;
            n_vec++;
            if ({bus.hold_out, bus.rom_req, bus.cache_wren, bus.cache_wrset, bus.cache_wrway,
                 bus.cache_wroffset, bus.rom_address} !== {3'b111, set, way, 3'(k), wa}) begin
                n_err++;
                $display("FAIL fill_word %h: got %h want %h", wa,
                         {bus.hold_out, bus.rom_req, bus.cache_wren, bus.cache_wrset, bus.cache_wrway,
                          bus.cache_wroffset, bus.rom_address}, {3'b111, set, way, 3'(k), wa});
            end
            clk_edge();
        end
        bus.rom_valid = 1'b0;
        #1;
        n_vec++;
        if ({bus.hold_out, bus.rom_req, bus.cache_wren, bus.pc, bus.cache_rdset, bus.cache_rdway,
             bus.cache_rdoffset} !== {3'b000, addr, set, way, addr[2:0]}) begin
            n_err++;
            $display("FAIL resume %h: got %h want %h", addr,
                     {bus.hold_out, bus.rom_req, bus.cache_wren, bus.pc, bus.cache_rdset, bus.cache_rdway,
                      bus.cache_rdoffset}, {3'b000, addr, set, way, addr[2:0]});
        end
        clk_edge();
    endtask

    task automatic run_hits(input int n);
        for (int i = 0; i < n; i++) begin
            exp_pc = exp_pc + 8'd1;
            #1;
            n_vec++;
            if ({bus.hold_out, bus.rom_req, bus.cache_rdset, bus.cache_rdoffset} !== {2'b00, exp_pc[3], exp_pc[2:0]}) begin
                n_err++;
                $display("FAIL seq_hit %h: got %b want %b", exp_pc,
                         {bus.hold_out, bus.rom_req, bus.cache_rdset, bus.cache_rdoffset},
                         {2'b00, exp_pc[3], exp_pc[2:0]});
            end
            clk_edge();
            exp_hit++;
            n_vec++;
            if (bus.pc !== exp_pc) begin
                n_err++;
                $display("FAIL seq_pc: got %h want %h", bus.pc, exp_pc);
            end
        end
    endtask

    // Jump that must hit; rom_valid is asserted to show it is ignored outside a fill.
    task automatic jump_hit(input logic j, input logic jnz, input logic dj, input logic [3:0] ja,
                            input logic [7:0] target, input logic way);
        bus.jmp       = j;
        bus.jmp_nz    = jnz;
        bus.dont_jmp  = dj;
        bus.jmp_addr  = ja;
        bus.rom_valid = 1'b1;
        exp_pc        = target;
        #1;
        n_vec++;
        if ({bus.hold_out, bus.rom_req, bus.cache_wren, bus.cache_rdway, bus.cache_rdoffset} !==
            {3'b000, way, target[2:0]}) begin
            n_err++;
            $display("FAIL jump_hit %h: got %b want %b", target,
                     {bus.hold_out, bus.rom_req, bus.cache_wren, bus.cache_rdway, bus.cache_rdoffset},
                     {3'b000, way, target[2:0]});
        end
        clk_edge();
        idle_inputs();
        exp_hit++;
        n_vec++;
        if (bus.pc !== target) begin
            n_err++;
            $display("FAIL jump_pc: got %h want %h", bus.pc, target);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        idle_inputs();
        exp_hit  = 16'd0;
        exp_miss = 16'd0;
        exp_pc   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.pc, bus.rom_req, bus.cache_wren, bus.hold_out, bus.rom_address} !== {8'h00, 3'b001, 8'h00}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h",
                     {bus.pc, bus.rom_req, bus.cache_wren, bus.hold_out, bus.rom_address}, {8'h00, 3'b001, 8'h00});
        end
        n_vec++;
        if ({bus.hit_count, bus.miss_count} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_counters: got %h want 0", {bus.hit_count, bus.miss_count});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_first_fill();
        miss_fill(8'h00, 1'b0, 0, 1'b0);
        run_hits(7);
        n_vec++;
        if ({bus.hit_count, bus.miss_count} !== {16'd7, 16'd1}) begin
            n_err++;
            $display("FAIL first_counters: got %h want %h", {bus.hit_count, bus.miss_count}, {16'd7, 16'd1});
        end
    endtask

    task automatic test_seq_line();
        miss_fill(8'h08, 1'b0, 0, 1'b0);
        run_hits(1);
        n_vec++;
        if ({bus.hit_count, bus.miss_count} !== {16'd8, 16'd2}) begin
            n_err++;
            $display("FAIL seq_counters: got %h want %h", {bus.hit_count, bus.miss_count}, {16'd8, 16'd2});
        end
    endtask

    task automatic test_wrap();
        bus.jmp      = 1'b1;
        bus.jmp_addr = 4'hF;
        miss_fill(8'hF0, 1'b1, 0, 1'b0);
        run_hits(7);
        miss_fill(8'hF8, 1'b1, 0, 1'b0);
        run_hits(8);
        n_vec++;
        if ({bus.pc, bus.hit_count, bus.miss_count} !== {8'h00, 16'd23, 16'd4}) begin
            n_err++;
            $display("FAIL wrap_state: got %h want %h", {bus.pc, bus.hit_count, bus.miss_count},
                     {8'h00, 16'd23, 16'd4});
        end
    endtask

    task automatic test_victim_and_stall();
        bus.jmp      = 1'b1;
        bus.jmp_addr = 4'h3;
        miss_fill(8'h30, 1'b0, 0, 1'b0);
        bus.jmp      = 1'b1;
        bus.jmp_addr = 4'h5;
        miss_fill(8'h50, 1'b1, 0, 1'b0);
        bus.jmp      = 1'b1;
        bus.jmp_addr = 4'h0;
        miss_fill(8'h00, 1'b0, 3, 1'b1);
        run_hits(1);
        jump_hit(1'b1, 1'b0, 1'b0, 4'h5, 8'h50, 1'b1);
        n_vec++;
        if ({bus.hit_count, bus.miss_count} !== {16'd25, 16'd7}) begin
            n_err++;
            $display("FAIL victim_counters: got %h want %h", {bus.hit_count, bus.miss_count}, {16'd25, 16'd7});
        end
    endtask

    task automatic test_jmp_nz();
        jump_hit(1'b0, 1'b1, 1'b1, 4'hA, 8'h51, 1'b1);
        jump_hit(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
        jump_hit(1'b1, 1'b1, 1'b0, 4'h5, 8'h50, 1'b1);
        n_vec++;
        if ({bus.hit_count, bus.miss_count} !== {16'd28, 16'd7}) begin
            n_err++;
            $display("FAIL jnz_counters: got %h want %h", {bus.hit_count, bus.miss_count}, {16'd28, 16'd7});
        end
    endtask

    task automatic test_flush_and_reset();
        logic [7:0] wa;
        bus.jmp_nz   = 1'b1;
        bus.jmp_addr = 4'hA;
        #1;
        n_vec++;
        if ({bus.hold_out, bus.rom_req} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_miss: got %b want 10", {bus.hold_out, bus.rom_req});
        end
        clk_edge();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            wa            = 8'hA0 | 8'(k);
            bus.rom_valid = 1'b1;
            #1;
            n_vec++;
            if ({bus.rom_req, bus.cache_wren, bus.cache_wrway, bus.rom_address} !== {3'b111, wa}) begin
                n_err++;
                $display("FAIL pre_flush_word %h: got %h want %h", wa,
                         {bus.rom_req, bus.cache_wren, bus.cache_wrway, bus.rom_address}, {3'b111, wa});
            end
            clk_edge();
        end
        bus.flush     = 1'b1;
        bus.rom_valid = 1'b1;
        #1;
        n_vec++;
        if (bus.cache_wren !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wren: got %b want 0", bus.cache_wren);
        end
        clk_edge();
        idle_inputs();
        #1;
        n_vec++;
        if ({bus.pc, bus.hold_out, bus.rom_req, bus.hit_count, bus.miss_count} !== {8'h00, 2'b10, 16'd28, 16'd8}) begin
            n_err++;
            $display("FAIL post_flush: got %h want %h", {bus.pc, bus.hold_out, bus.rom_req, bus.hit_count, bus.miss_count},
                     {8'h00, 2'b10, 16'd28, 16'd8});
        end
        clk_edge();
        for (int k = 0; k < 2; k++) begin
            wa            = 8'(k);
            bus.rom_valid = 1'b1;
            #1;
            n_vec++;
            if ({bus.rom_req, bus.cache_wren, bus.cache_wrset, bus.cache_wrway, bus.rom_address} !== {4'b1100, wa}) begin
                n_err++;
                $display("FAIL refill_word %h: got %h want %h", wa,
                         {bus.rom_req, bus.cache_wren, bus.cache_wrset, bus.cache_wrway, bus.rom_address}, {4'b1100, wa});
            end
            clk_edge();
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.rom_req, bus.cache_wren, bus.hold_out, bus.pc, bus.rom_address, bus.hit_count, bus.miss_count} !==
            {3'b001, 8'h00, 8'h00, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid_fill: got %h want %h",
                     {bus.rom_req, bus.cache_wren, bus.hold_out, bus.pc, bus.rom_address, bus.hit_count, bus.miss_count},
                     {3'b001, 8'h00, 8'h00, 32'h0});
        end
        idle_inputs();
        clk_edge();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_seq_line();
        test_wrap();
        test_victim_and_stall();
        test_jmp_nz();
        test_flush_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
